// File: rtl/fifo_pkg.sv
// Shared helpers for the fifo_flow elastic buffer: pointer wrap and count width.
package fifo_pkg;

  // Wrap-aware pointer increment; works for any depth, not only powers of two.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  // Width needed to hold an occupancy value of 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_flow_if.sv
// Stream bundle around fifo_flow: input side, output side, flush and status.
// Handshake: a transfer happens on a rising edge where req and ack of the same
// side are both high; data is sampled at that edge. ack_in never depends on
// ack_out, and the producer must not wait for ack before raising req.
interface fifo_flow_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 7
);
  localparam int CW = fifo_pkg::cnt_w(DEPTH);

  logic          flush;
  logic [DW-1:0] d_in;
  logic          req_in;
  logic          ack_in;
  logic [DW-1:0] d_out;
  logic          req_out;
  logic          ack_out;
  logic [CW-1:0] count;
  logic          almost_full;

  // Environment side: produces input data, consumes output data.
  modport master (
    output flush, d_in, req_in, ack_out,
    input  ack_in, d_out, req_out, count, almost_full
  );

  // Buffer side.
  modport slave (
    input  flush, d_in, req_in, ack_out,
    output ack_in, d_out, req_out, count, almost_full
  );
endinterface

// File: rtl/fifo_mem.sv
// DW x DEPTH register array: one synchronous write port, one asynchronous read port.
// Data is intentionally not reset; only pointers and count define validity.
module fifo_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 7,
  parameter int PW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Write the selected entry on an accepted store.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_flow.sv
// Parametrised req/ack elastic buffer with optional fall-through when empty,
// occupancy count, registered almost-full flag and synchronous flush.
module fifo_flow
  import fifo_pkg::*;
#(
  parameter int DW     = 8,
  parameter int DEPTH  = 7,
  parameter int BYPASS = 1,
  parameter int AF_LVL = DEPTH - 1
) (
  input  logic        clk,
  input  logic        rst,
  fifo_flow_if.slave  io
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_next;
  logic          af;
  logic          empty, full, byp;
  logic          push, pop, store, take;
  logic [DW-1:0] rd_data;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  // Fall-through only applies in bypass mode while nothing is stored, so
  // bypassed data can never overtake stored data.
  assign byp   = (BYPASS != 0) && empty;

  assign io.ack_in  = ~rst & ~io.flush & ~full;
  assign io.req_out = ~rst & ~io.flush & (byp ? io.req_in : ~empty);
  assign io.d_out   = byp ? io.d_in : rd_data;

  assign push  = io.req_in & io.ack_in;
  assign pop   = io.req_out & io.ack_out;
  // A bypassed push that is popped the same cycle passes straight through.
  assign store = push & ~(byp & io.ack_out);
  assign take  = pop & ~byp;

  // Next occupancy: flush wins, otherwise +store -take.
  always_comb begin
    cnt_next = cnt;
    if (io.flush) begin
      cnt_next = '0;
    end else begin
      case ({store, take})
        2'b10:   cnt_next = cnt + CW'(1);
        2'b01:   cnt_next = cnt - CW'(1);
        default: cnt_next = cnt;
      endcase
    end
  end

  // Pointer, count and almost-full state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      af  <= 1'b0;
    end else begin
      if (io.flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (store) wp <= PW'(ptr_inc(int'(wp), DEPTH));
        if (take)  rp <= PW'(ptr_inc(int'(rp), DEPTH));
      end
      cnt <= cnt_next;
      af  <= (cnt_next >= CW'(AF_LVL));
    end
  end

  assign io.count       = cnt;
  assign io.almost_full = af;

  fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (store),
    .waddr (wp),
    .wdata (io.d_in),
    .raddr (rp),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_fifo_flow.sv
// Directed bench for fifo_flow: bypass DUT (DEPTH 4), registered DUT (DEPTH 4)
// and a DEPTH 7 bypass DUT for wrap-around streaming.
module tb_fifo_flow;
  logic clk;
  logic rst;

  int tests;
  int fails;

  fifo_flow_if #(.DW(8), .DEPTH(4)) bi ();
  fifo_flow_if #(.DW(8), .DEPTH(4)) ri ();
  fifo_flow_if #(.DW(8), .DEPTH(7)) wi ();

  fifo_flow #(.DW(8), .DEPTH(4), .BYPASS(1), .AF_LVL(3)) u_byp (.clk(clk), .rst(rst), .io(bi));
  fifo_flow #(.DW(8), .DEPTH(4), .BYPASS(0), .AF_LVL(3)) u_reg (.clk(clk), .rst(rst), .io(ri));
  fifo_flow #(.DW(8), .DEPTH(7), .BYPASS(1))             u_wrap (.clk(clk), .rst(rst), .io(wi));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  int         sent;
  int         recv;
  int         cyc;

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    {bi.flush, bi.d_in, bi.req_in, bi.ack_out} = '0;
    {ri.flush, ri.d_in, ri.req_in, ri.ack_out} = '0;
    {wi.flush, wi.d_in, wi.req_in, wi.ack_out} = '0;

    // Reset values
    #2;
    check("rst_ack_in", bi.ack_in, 0);
    check("rst_req_out", bi.req_out, 0);
    check("rst_count", bi.count, 0);
    check("rst_af", bi.almost_full, 0);
    bi.req_in = 1'b1;
    #1;
    check("rst_req_out_gated", bi.req_out, 0);
    bi.req_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ack_in", bi.ack_in, 1);
    check("post_rst_count", bi.count, 0);

    // Bypass pass-through
    bi.ack_out = 1'b1;
    bi.req_in  = 1'b1;
    bi.d_in    = 8'h11;
    #1;
    check("byp_d_out", bi.d_out, 8'h11);
    check("byp_req_out", bi.req_out, 1);
    tick();
    bi.req_in = 1'b0;
    check("byp_count", bi.count, 0);

    // Fill and hold
    bi.ack_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bi.req_in = 1'b1;
      bi.d_in   = 8'hA0 + 8'(i);
      #1;
      check("fill_ack_in", bi.ack_in, 1);
      if (i == 0) check("fill_first_d_out", bi.d_out, 8'hA0);
      tick();
      check("fill_count", bi.count, i + 1);
      check("fill_af", bi.almost_full, (i + 1 >= 3) ? 1 : 0);
    end
    bi.d_in = 8'hA4;
    #1;
    check("full_ack_in", bi.ack_in, 0);
    tick();
    check("full_no_push", bi.count, 4);

    // Full with simultaneous pop
    bi.ack_out = 1'b1;
    #1;
    check("fullpop_d_out", bi.d_out, 8'hA0);
    check("fullpop_ack_in", bi.ack_in, 0);
    tick();
    check("fullpop_count", bi.count, 3);
    check("fullpop_af", bi.almost_full, 1);
    check("next_ack_in", bi.ack_in, 1);
    check("next_d_out", bi.d_out, 8'hA1);
    tick();
    bi.req_in = 1'b0;
    check("pushpop_count", bi.count, 3);
    for (int i = 2; i < 5; i++) begin
      #1;
      check("drain_req_out", bi.req_out, 1);
      check("drain_d_out", bi.d_out, 8'hA0 + 8'(i));
      tick();
      check("drain_count", bi.count, 4 - i);
    end
    check("drain_af", bi.almost_full, 0);
    check("drain_empty_req", bi.req_out, 0);

    // Registered mode
    ri.ack_out = 1'b1;
    ri.req_in  = 1'b1;
    ri.d_in    = 8'h5A;
    #1;
    check("reg_no_fallthru", ri.req_out, 0);
    tick();
    ri.req_in = 1'b0;
    check("reg_req_out", ri.req_out, 1);
    check("reg_d_out", ri.d_out, 8'h5A);
    check("reg_count1", ri.count, 1);
    tick();
    check("reg_count0", ri.count, 0);
    check("reg_req_out0", ri.req_out, 0);
    for (int k = 0; k < 3; k++) begin
      ri.req_in = 1'b1;
      ri.d_in   = 8'hB0 + 8'(k);
      #1;
      if (k > 0) begin
        check("reg_stream_req", ri.req_out, 1);
        check("reg_stream_d", ri.d_out, 8'hB0 + 8'(k - 1));
      end
      tick();
      check("reg_stream_count", ri.count, 1);
    end
    ri.req_in = 1'b0;
    #1;
    check("reg_stream_last", ri.d_out, 8'hB2);
    tick();
    check("reg_stream_empty", ri.count, 0);

    // Flush
    bi.ack_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bi.req_in = 1'b1;
      bi.d_in   = 8'hC0 + 8'(i);
      tick();
    end
    bi.req_in = 1'b0;
    check("pre_flush_count", bi.count, 3);
    bi.flush = 1'b1;
    #1;
    check("flush_ack_in", bi.ack_in, 0);
    check("flush_req_out", bi.req_out, 0);
    tick();
    bi.flush = 1'b0;
    check("flush_count", bi.count, 0);
    check("flush_af", bi.almost_full, 0);
    check("flush_req_out_after", bi.req_out, 0);
    bi.req_in = 1'b1;
    bi.d_in   = 8'hD0;
    tick();
    bi.req_in = 1'b0;
    check("flush_first_req", bi.req_out, 1);
    check("flush_first_d", bi.d_out, 8'hD0);
    check("flush_first_count", bi.count, 1);
    bi.ack_out = 1'b1;
    tick();
    check("flush_drained", bi.count, 0);

    // Wrap-around on DEPTH 7 with random handshakes
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 20 && cyc < 400) begin
      wi.req_in  = (sent < 20) && ($urandom_range(0, 3) != 0);
      wi.d_in    = 8'($urandom_range(0, 255));
      wi.ack_out = (cyc < 30) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      #1;
      if (wi.req_in && wi.ack_in) begin
        exp_q.push_back(wi.d_in);
        sent++;
      end
      if (wi.req_out && wi.ack_out) begin
        if (exp_q.size() == 0) begin
          check("wrap_spurious_out", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("wrap_data", wi.d_out, exp_v);
        end
        recv++;
      end
      tick();
      check("wrap_count_le7", (wi.count <= 3'd7) ? 1 : 0, 1);
      cyc++;
    end
    wi.req_in  = 1'b0;
    wi.ack_out = 1'b0;
    check("wrap_all_received", recv, 20);
    check("wrap_final_count", wi.count, 0);

    // Reset mid-stream
    bi.ack_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bi.req_in = 1'b1;
      bi.d_in   = 8'hE0 + 8'(i);
      tick();
    end
    check("mid_pre_count", bi.count, 3);
    check("mid_pre_af", bi.almost_full, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_count", bi.count, 0);
    check("mid_rst_ack_in", bi.ack_in, 0);
    check("mid_rst_req_out", bi.req_out, 0);
    check("mid_rst_af", bi.almost_full, 0);
    bi.req_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("mid_post_ack_in", bi.ack_in, 1);
    check("mid_post_req_out", bi.req_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_flow.md
# fifo_flow

Parametrised req/ack FIFO buffer, the next generation of the team's zero-latency bypass FIFO. Depth is any value ≥ 2, and a mode parameter selects between combinational fall-through and registered output. It adds an occupancy count, an almost-full flag and a synchronous flush. It sits between any two req/ack stream stages in the datapath as the standard elastic buffer.

## Interface
- `DW`, 8: data width in bits.
- `DEPTH`, 7: number of storage entries, ≥ 2, not necessarily a power of two.
- `BYPASS`, 1: 1 means fall-through when empty (0-cycle latency); 0 means every item is stored first (≥ 1-cycle latency).
- `AF_LVL`, DEPTH-1: `almost_full` asserts when count ≥ AF_LVL; legal range 1..DEPTH.

Ports:
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of all stored entries.
- `d_in` in DW: input data.
- `req_in` in 1: input valid.
- `ack_in` out 1: input ready.
- `d_out` out DW: output data.
- `req_out` out 1: output valid.
- `ack_out` in 1: output ready.
- `count` out $clog2(DEPTH+1): number of stored entries.
- `almost_full` out 1: registered threshold flag.

## Operation
- **Transfer rule.** A transfer happens on any cycle where req and ack are both high on the same side. `d_in`/`d_out` are sampled at that edge.
- **Storage.** Circular buffer with write pointer `wp` and read pointer `rp`, each 0..DEPTH-1. Each pointer wraps from DEPTH-1 to 0 with an explicit compare, not modulo-2^n. `count` is held in a register; full = (count == DEPTH) and empty = (count == 0).
- **ack_in.** `ack_in = ~full & ~flush`. It depends on state only and never on `ack_out`. When full, no push occurs even if a pop happens the same cycle.
- **BYPASS=1, empty.**
  - `req_out = req_in` and `d_out = d_in`.
  - If `req_in & ack_out`, the item passes straight through: nothing is stored and `count` is unchanged.
  - If `req_in & ~ack_out`, the item is written into storage.
- **BYPASS=0, or not empty.** `req_out = ~empty` and `d_out = mem[rp]`.
- **Simultaneous push and pop when not empty.** `wp` and `rp` both advance and `count` is unchanged. Ordering is strict FIFO; bypass never overtakes stored data.
- **flush.**
  - Forces `ack_in = 0` and `req_out = 0` during the flush cycle.
  - At the edge, `wp`, `rp` and `count` all become 0.
  - No transfer is counted that cycle on either side.
  - Memory contents are don't-care.
- **almost_full.** Registered from the next-state count (count_next ≥ AF_LVL), so it is aligned with `count`.

## Timing
- **Reset values** while `rst` is high and after release: `ack_in` 0 during reset, then 1 the cycle after release; `req_out` 0; `d_out` don't-care; `count` 0; `almost_full` 0 (1 only if AF_LVL = 0, which is illegal).
  - `ack_in` and `req_out` are gated with `~rst` so that nothing transfers during reset.
- **Latency.**
  - BYPASS=1, empty: 0 cycles, combinational `d_in`→`d_out`.
  - BYPASS=0: an item pushed at edge N is presented with `req_out` = 1 after edge N.
- **Throughput.** Sustained one transfer per cycle on both sides in both modes, except when full (see the `ack_in` rule).
- **Reset mid-operation.** `rst` asserted asynchronously clears pointers and count immediately; in-flight data is lost.
- **Combinational paths.**
  - BYPASS=1: `req_in`→`req_out` and `d_in`→`d_out` when empty.
  - No path from `ack_out` to `ack_in` in either mode.
  - BYPASS=0: no input-to-output combinational path at all.

## Structure
- **Package `fifo_pkg`:**
  - Function `ptr_inc(ptr, DEPTH)` for wrap-aware increment.
  - Function `cnt_w(DEPTH)` returning $clog2(DEPTH+1).
- **Sub-module `fifo_mem`:** DW×DEPTH register array with one synchronous write port and one asynchronous read port. No reset on the data.
- **Top-level contents:** pointers, count, flags, bypass mux and handshake gating.

## Test plan
Unless stated, the bench uses DW=8, DEPTH=4, AF_LVL=3.

- **Bypass pass-through:** BYPASS=1, empty, `ack_out`=1, push 0x11 → `d_out`=0x11 and `req_out`=1 in the same cycle; `count` stays 0.
- **Fill and hold:** BYPASS=1, `ack_out`=0, push 0xA0..0xA3.
  - `count` 1,2,3,4; `almost_full` rises after the 3rd push.
  - `ack_in`=0 at count 4; a 5th `req_in` is not accepted.
  - After raising `ack_out`, the output order is A0,A1,A2,A3.
- **Full with simultaneous pop:** count=4, `req_in`=1, `ack_out`=1 → exactly one pop, no push, count=3; the next cycle accepts the push.
- **Registered mode:** BYPASS=0, empty, `ack_out`=1, push 0x5A at edge N → `req_out`=1 with `d_out`=0x5A only after edge N; `count` returns to 0 after the pop.
- **Wrap-around:** DEPTH=7 (non-power-of-two), 20 items streamed with random `req_in`/`ack_out` → output matches input in order with no loss or duplication; `count` never exceeds 7.
- **Flush and reset:**
  - flush at count=3 → count=0, `req_out`=0 the next cycle, and a push the following cycle is output as the first item.
  - `rst` pulsed mid-stream → all outputs take their reset values asynchronously.
